// File: rtl/wf_timer_pkg.sv
// -----------------------------------------------------------------------------
// wf_timer_pkg
// Shared types and constants for the wf_timer_gen timer family.
//   - state_e      : timer state (IDLE/RUN); RUN is what drives `running`.
//   - cmd_e        : per-cycle command after priority resolution. The enum
//                    value is the priority rank (higher value wins).
//   - decode_cmd() : resolves stop > start > counting into one command.
//   - WF_DEFAULT_* : default width / terminal count, reused by chained
//                    instances so a time-base chain agrees on its defaults.
// Optional feature macro used by the family: WF_TIMER_PWM_EN.
// -----------------------------------------------------------------------------
package wf_timer_pkg;

  localparam int WF_DEFAULT_WIDTH        = 16;
  localparam int WF_DEFAULT_RESET_PERIOD = 499;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Priority ranks: stop beats start, start beats an ordinary count tick.
  localparam logic [1:0] CMD_PRIO_HOLD  = 2'd0;
  localparam logic [1:0] CMD_PRIO_COUNT = 2'd1;
  localparam logic [1:0] CMD_PRIO_START = 2'd2;
  localparam logic [1:0] CMD_PRIO_STOP  = 2'd3;

  typedef enum logic [1:0] {
    CMD_HOLD  = CMD_PRIO_HOLD,
    CMD_COUNT = CMD_PRIO_COUNT,
    CMD_START = CMD_PRIO_START,
    CMD_STOP  = CMD_PRIO_STOP
  } cmd_e;

  // tick = RUN and enable; the counter only moves on a tick.
  function automatic cmd_e decode_cmd(input logic stop, input logic start,
                                      input logic tick);
    cmd_e cmd;
    cmd = CMD_HOLD;
    if (stop)       cmd = CMD_STOP;
    else if (start) cmd = CMD_START;
    else if (tick)  cmd = CMD_COUNT;
    return cmd;
  endfunction

endpackage

// File: rtl/wf_timer_pwm.sv
// -----------------------------------------------------------------------------
// wf_timer_pwm
// Registered comparator producing a PWM waveform from the timer count.
// It is fed the timer's *next* state so that, on every cycle, pwm_out agrees
// with the registered `running` and `count` outputs it is compared against:
//   pwm_out == running && (count < compare)
// Only instantiated when WF_TIMER_PWM_EN is defined.
// Ports:
//   clk          in   core clock
//   reset_n      in   synchronous active-low reset (pwm_out -> 0)
//   running_next in   timer state for the next cycle (1 = RUN)
//   count_next   in   counter value for the next cycle
//   compare      in   duty threshold; 0 = never high, > period = always high
//   pwm_out      out  registered PWM output
// -----------------------------------------------------------------------------
module wf_timer_pwm #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             running_next,
  input  logic [WIDTH-1:0] count_next,
  input  logic [WIDTH-1:0] compare,
  output logic             pwm_out
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= running_next && (count_next < compare);
    end
  end

endmodule

// File: rtl/wf_timer_gen.sv
// -----------------------------------------------------------------------------
// wf_timer_gen
// Parametrised timer/counter with runtime-loadable terminal count, start/stop
// control, one-shot or periodic mode. timer_pulse of one instance can drive
// enable of the next to build cascaded time bases.
// Optional feature: define WF_TIMER_PWM_EN to add `compare` / `pwm_out`.
// Ports:
//   clk          in   core clock, rising edge
//   reset_n      in   synchronous active-low reset
//   enable       in   count qualifier (ignored in IDLE)
//   start        in   strobe: clear counter, enter RUN
//   stop         in   strobe: enter IDLE, counter frozen (beats start)
//   load         in   strobe: write load_value into the period register
//   load_value   in   new terminal count
//   oneshot      in   1 = go IDLE after the terminal event (sampled there)
//   count        out  registered counter value
//   running      out  1 while in RUN (this is the complete FSM state)
//   timer_pulse  out  registered one-clock pulse per terminal event
//   compare      in   [WF_TIMER_PWM_EN] PWM threshold
//   pwm_out      out  [WF_TIMER_PWM_EN] registered PWM output
// Handshake: none; all controls are single-cycle strobes sampled at the clk
// edge, with no back-pressure. stop > start > counting within one cycle;
// load is independent and always takes effect at the edge it is sampled.
// -----------------------------------------------------------------------------
module wf_timer_gen
  import wf_timer_pkg::*;
#(
  parameter int WIDTH        = WF_DEFAULT_WIDTH,
  parameter int RESET_PERIOD = WF_DEFAULT_RESET_PERIOD,
  parameter bit AUTO_START   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             timer_pulse
`ifdef WF_TIMER_PWM_EN
  ,
  input  logic [WIDTH-1:0] compare,
  output logic             pwm_out
`endif
);

  localparam logic [WIDTH-1:0] RESET_PERIOD_W = WIDTH'(RESET_PERIOD);
  localparam state_e           RESET_STATE    = AUTO_START ? ST_RUN : ST_IDLE;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] period_q;
  logic             pulse_d;
  logic             terminal;
  cmd_e             cmd;

  // >= rather than == so that lowering the period below the live count ends
  // the cycle on the next tick instead of wrapping through 2^WIDTH.
  assign terminal = (count >= period_q);
  assign running  = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    count_d = count;
    pulse_d = 1'b0;
    cmd     = decode_cmd(stop, start, (state_q == ST_RUN) && enable);
    case (cmd)
      CMD_STOP: begin
        state_d = ST_IDLE;
      end
      CMD_START: begin
        state_d = ST_RUN;
        count_d = '0;
      end
      CMD_COUNT: begin
        if (terminal) begin
          pulse_d = 1'b1;
          count_d = '0;
          if (oneshot) state_d = ST_IDLE;
        end else begin
          count_d = count + WIDTH'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      count       <= '0;
      timer_pulse <= 1'b0;
      period_q    <= RESET_PERIOD_W;
    end else begin
      state_q     <= state_d;
      count       <= count_d;
      timer_pulse <= pulse_d;
      // Counting this cycle already used the old period_q via `terminal`.
      if (load) period_q <= load_value;
    end
  end

`ifdef WF_TIMER_PWM_EN
  wf_timer_pwm #(
    .WIDTH(WIDTH)
  ) u_pwm (
    .clk          (clk),
    .reset_n      (reset_n),
    .running_next (state_d == ST_RUN),
    .count_next   (count_d),
    .compare      (compare),
    .pwm_out      (pwm_out)
  );
`endif

endmodule

// File: tb/tb_wf_timer_gen.sv
// -----------------------------------------------------------------------------
// tb_wf_timer_gen
// Self-checking bench for wf_timer_gen: table of directed vectors, hand-written
// multi-cycle sequences and a randomized phase checked against a behavioural
// model. A second instance with AUTO_START=1 covers the free-running reset.
// -----------------------------------------------------------------------------
module tb_wf_timer_gen;

  localparam int W  = 16;
  localparam int WA = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main DUT ----------------
  logic         enable = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0, oneshot = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count;
  logic         running, timer_pulse;
  logic [W-1:0] cmp = '0;
  logic         pwm_out;

  wf_timer_gen #(.WIDTH(W), .RESET_PERIOD(499), .AUTO_START(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .stop(stop),
    .load(load), .load_value(load_value), .oneshot(oneshot),
    .count(count), .running(running), .timer_pulse(timer_pulse)
`ifdef WF_TIMER_PWM_EN
    , .compare(cmp), .pwm_out(pwm_out)
`endif
  );

  // ---------------- free-running DUT ----------------
  logic          en_a = 1'b1;
  logic          zero_a = 1'b0;
  logic [WA-1:0] lv_a = '0;
  logic [WA-1:0] count_a;
  logic          running_a, pulse_a;
  logic [WA-1:0] cmp_a = '0;
  logic          pwm_a;

  wf_timer_gen #(.WIDTH(WA), .RESET_PERIOD(3), .AUTO_START(1'b1)) dut_auto (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .start(zero_a), .stop(zero_a),
    .load(zero_a), .load_value(lv_a), .oneshot(zero_a),
    .count(count_a), .running(running_a), .timer_pulse(pulse_a)
`ifdef WF_TIMER_PWM_EN
    , .compare(cmp_a), .pwm_out(pwm_a)
`endif
  );

`ifndef WF_TIMER_PWM_EN
  assign pwm_out = 1'b0;
  assign pwm_a   = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_count, m_period;
  bit m_run, m_pulse, m_pwm;

  task automatic model_reset();
    m_count = 0; m_period = 499; m_run = 0; m_pulse = 0; m_pwm = 0;
  endtask

  // One clock: drive inputs, advance the model by the spec's rules, wait for
  // the edge, then compare every output against the model.
  task automatic cycle(input bit en, input bit st, input bit sp, input bit ld,
                       input int lv, input bit os);
    int n_count, n_period;
    bit n_run, n_pulse;
    enable = en; start = st; stop = sp; load = ld; load_value = W'(lv); oneshot = os;
    n_count = m_count; n_period = m_period; n_run = m_run; n_pulse = 0;
    if (sp) n_run = 0;
    else if (st) begin n_run = 1; n_count = 0; end
    else if (m_run && en) begin
      if (m_count >= m_period) begin
        n_pulse = 1; n_count = 0;
        if (os) n_run = 0;
      end else n_count = m_count + 1;
    end
    if (ld) n_period = lv;
    @(posedge clk);
    #1;
    m_count = n_count; m_period = n_period; m_run = n_run; m_pulse = n_pulse;
    m_pwm = m_run && (m_count < int'(cmp));
    chk("model_count", count, m_count);
    chk("model_running", running, m_run);
    chk("model_pulse", timer_pulse, m_pulse);
`ifdef WF_TIMER_PWM_EN
    chk("model_pwm", pwm_out, m_pwm);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit en, st, sp, ld;
    int lv;
    bit os;
    int ec;
    bit er, ep;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit en, bit st, bit sp, bit ld, int lv, bit os,
                              int ec, bit er, bit ep);
    vec_t v;
    v.en = en; v.st = st; v.sp = sp; v.ld = ld; v.lv = lv; v.os = os;
    v.ec = ec; v.er = er; v.ep = ep;
    return v;
  endfunction

  initial begin
    int ticks, pulses, pulse_tick, highs, n;
    bit en;

    // ---- reset, AUTO_START=0 and AUTO_START=1 ----
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_running", running, 0);
    chk("rst_pulse", timer_pulse, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_auto_running", running_a, 1);
    chk("rst_auto_count", count_a, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("auto_first_running", running_a, 1);
    chk("auto_first_count", count_a, 1);
    chk("idle_after_rst_running", running, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("auto_pulse", pulse_a, 1);
    chk("auto_pulse_count", count_a, 0);
    @(posedge clk); #1;
    chk("auto_pulse_clear", pulse_a, 0);
    chk("auto_count_resume", count_a, 1);

    // ---- table: en st sp ld lv os | count run pulse ----
    tbl.push_back(mk(1,0,0,1,2,0, 0,0,0)); // load while idle, enable ignored
    tbl.push_back(mk(1,1,0,0,0,0, 0,1,0)); // start
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0)); // enable low holds
    tbl.push_back(mk(1,0,0,0,0,0, 2,1,0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,1,1)); // terminal, periodic
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,0)); // pulse drops regardless of enable
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,0,0,0,0,0, 2,1,0));
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,1)); // oneshot sampled at terminal
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0, 0,1,0)); // start + load(0) together
    tbl.push_back(mk(1,0,0,1,3,0, 0,1,1)); // old period 0 used this cycle
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,0,0,0,0,0, 2,1,0));
    tbl.push_back(mk(1,0,0,0,0,0, 3,1,0));
    tbl.push_back(mk(1,0,1,0,0,0, 3,0,0)); // stop beats terminal
    tbl.push_back(mk(1,0,0,0,0,0, 3,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,1,0)); // start after stop clears
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,1,0,0,0,0, 0,1,0)); // restart while running
    tbl.push_back(mk(1,1,1,0,0,0, 0,0,0)); // stop beats start
    tbl.push_back(mk(0,1,0,1,0,0, 0,1,0)); // period 0
    tbl.push_back(mk(1,0,0,0,0,0, 0,1,1));
    tbl.push_back(mk(1,0,0,0,0,0, 0,1,1)); // pulse held with constant enable
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,0));
    foreach (tbl[i]) begin
      cycle(tbl[i].en, tbl[i].st, tbl[i].sp, tbl[i].ld, tbl[i].lv, tbl[i].os);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].ec);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].er);
      chk($sformatf("tbl%0d_pulse", i), timer_pulse, tbl[i].ep);
    end

    // ---- period 4 periodic: pulse every 5 clks ----
    cycle(0,1,0,1,4,0);
    chk("t2_start_count", count, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle(1,0,0,0,0,0);
      chk("t2_count", count, k % 5);
      chk("t2_pulse", timer_pulse, (k % 5) == 0);
    end

    // ---- period 9 oneshot, enable every 3rd clk ----
    cycle(0,1,0,1,9,1);
    ticks = 0; pulses = 0; pulse_tick = 0;
    for (int i = 0; i < 45; i++) begin
      en = (i % 3) == 2;
      cycle(en,0,0,0,0,1);
      if (en) ticks++;
      if (timer_pulse) begin pulses++; pulse_tick = ticks; end
    end
    chk("t3_pulses", pulses, 1);
    chk("t3_pulse_tick", pulse_tick, 10);
    chk("t3_running", running, 0);
    chk("t3_count", count, 0);

    // ---- lower period below live count ----
    cycle(0,1,0,1,20,0);
    repeat (7) cycle(1,0,0,0,0,0);
    chk("t4_count7", count, 7);
    cycle(0,0,0,1,5,0);
    chk("t4_load_keeps_count", count, 7);
    cycle(1,0,0,0,0,0);
    chk("t4_pulse", timer_pulse, 1);
    chk("t4_count0", count, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1,0,0,0,0,0);
      n++;
      if (timer_pulse) break;
    end
    chk("t4_next_period", n, 6);

`ifdef WF_TIMER_PWM_EN
    // ---- PWM: period 9, compare 3 ----
    cmp = 3;
    cycle(0,1,0,1,9,0);
    highs = pwm_out ? 1 : 0;
    for (int i = 0; i < 19; i++) begin
      cycle(1,0,0,0,0,0);
      if (pwm_out) highs++;
    end
    chk("t6_pwm_highs", highs, 6);
    cycle(0,1,0,0,0,0);
    cycle(1,0,1,0,0,0);
    chk("t6_pwm_stop", pwm_out, 0);
    cmp = 0;
`endif

    // ---- reset mid-count overrides strobes ----
    cycle(0,1,0,1,50,0);
    repeat (5) cycle(1,0,0,0,0,0);
    reset_n = 1'b0;
    enable = 1; start = 1; load = 1; load_value = 7;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_running", running, 0);
    chk("midrst_pulse", timer_pulse, 0);
    start = 0; load = 0; enable = 0;
    reset_n = 1'b1;
    model_reset();
    cycle(0,0,0,0,0,0);

    // ---- randomized phase against the model ----
    cycle(0,1,0,1,5,0);
    for (int i = 0; i < 1500; i++) begin
      cmp = W'($urandom_range(0, 14));
      cycle($urandom_range(0,3) != 0, $urandom_range(0,39) == 0,
            $urandom_range(0,59) == 0, $urandom_range(0,29) == 0,
            $urandom_range(0,12), $urandom_range(0,3) == 0);
      if (!m_run && $urandom_range(0,3) == 0) cycle(0,1,0,0,0,0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wf_timer_gen.md
Name: wf_timer_gen

Overview:
Parametrised general-purpose timer/counter, the next generation of the fixed 10-bit divider timer.
- Counter width is a parameter; the terminal count is runtime-loadable.
- Start/stop control, one-shot or periodic mode, and the live count is visible.
- Used standalone or chained: `timer_pulse` of one instance drives `enable` of the next to build time bases (10us -> 10ms -> 1s).

Parameters:
WIDTH, 16, counter and period register width in bits (2..32).
RESET_PERIOD, 499, terminal count loaded into the period register at reset; must fit in WIDTH bits.
AUTO_START, 0, 1 = timer enters RUN immediately after reset is released (free-running divider use).

Ports:
clk  input  1  core clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
enable  input  1  count qualifier; counter advances only on cycles with enable=1
start  input  1  1-cycle strobe: clear counter, enter RUN
stop  input  1  1-cycle strobe: enter IDLE, counter frozen
load  input  1  1-cycle strobe: write load_value into period register
load_value  input  WIDTH  new terminal count
oneshot  input  1  1 = return to IDLE after the first terminal event; 0 = periodic
count  output  WIDTH  current counter value (registered)
running  output  1  1 while in RUN
timer_pulse  output  1  one-clock pulse on each terminal event

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - count=0, timer_pulse=0, period=RESET_PERIOD.
  - running=AUTO_START.
  - Reset overrides all other inputs, including mid-count.
- States: IDLE, RUN. Encoded in `running`; no other state.
- IDLE: counter holds, enable ignored, timer_pulse=0.
- Command priority per cycle: stop > start > counting.
  - stop in any state -> IDLE next cycle; count retains its value; no pulse that cycle, even if the terminal condition was also met.
  - start (no stop) -> count=0, RUN next cycle. Applies in RUN too (restart). No pulse in the start cycle.
- Counting (RUN, enable=1, no stop/start):
  - If count >= period: timer_pulse=1 next cycle and count=0. If oneshot=1, go to IDLE; else stay in RUN.
  - Otherwise count=count+1.
- Terminal comparison is >=, not ==. If period is lowered below the current count, the next enabled tick terminates, with no 2^WIDTH wrap-around.
- Period: period=N gives exactly N+1 enabled ticks per pulse. period=0 pulses on every enabled tick (pulse held high continuously when enable=1 constantly).
- timer_pulse is registered; latency is 1 clk after the edge where the terminal tick is sampled. It is high for exactly one clk per event and deasserts the following cycle regardless of enable.
- load:
  - Writes the period register at the clk edge.
  - Counting in that same cycle compares against the old period; the new value applies from the next cycle.
  - load does not clear count.
  - load and start in the same cycle are both performed.
- oneshot is sampled at the terminal event, not at start.

Optional Feature:
WF_TIMER_PWM_EN:
- Defined:
  - Adds input `compare` (WIDTH) and output `pwm_out` (1).
  - pwm_out is registered: 1 when running=1 and count < compare; else 0. Reset value 0.
  - compare=0 gives constant 0; compare>period gives constant 1 while running.
- Undefined: both ports are absent and no compare logic is built; all other behaviour is identical.

Decomposition:
- Shared package wf_timer_pkg holds the state typedef (IDLE/RUN), the command-priority localparams, and the default WIDTH/RESET_PERIOD constants reused by chained instances.
- One sub-module is natural: wf_timer_pwm, the registered comparator, instantiated only under WF_TIMER_PWM_EN.
- Counter and control stay in the top module.

Test Plan:
1. reset_n=0 for 2 clks with AUTO_START=0 -> count=0, running=0, timer_pulse=0. With AUTO_START=1, running=1 on the first clk after release.
2. WIDTH=16, period=4, periodic, enable=1 constant, start -> timer_pulse high for 1 clk every 5 clks; count sequence 0,1,2,3,4,0...
3. period=9, oneshot=1, enable high every 3rd clk -> exactly one pulse after 10 enabled ticks; then running=0 and count=0 stays.
4. Count at 7 with period=20, load 5 -> next enabled tick gives pulse and count=0; following pulses every 6 enabled ticks.
5. stop and terminal condition in the same cycle (count=period=3) -> no pulse, running=0, count=3. A later start -> count=0, RUN.
6. WF_TIMER_PWM_EN defined, period=9, compare=3, enable=1 -> pwm_out high 3 of every 10 clks. stop -> pwm_out=0.
